// File: rtl/conv_result_serializer_pkg.sv
// Shared defaults and state encoding for the conv result serializer.
package conv_result_serializer_pkg;

    localparam int unsigned DefaultDataWidth = 16;
    localparam int unsigned DefaultN         = 128;
    localparam int unsigned DefaultIw        = $clog2(DefaultN);

    typedef enum logic {
        StIdle   = 1'b0,
        StStream = 1'b1
    } state_e;

endpackage

// File: rtl/conv_result_serializer_frame_word_mux.sv
// N-to-1 word selector: returns words[index], purely combinational.
module conv_result_serializer_frame_word_mux
    import conv_result_serializer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned N          = DefaultN,
    parameter int unsigned IW         = DefaultIw
) (
    input  logic [N-1:0][DATA_WIDTH-1:0] words,
    input  logic [IW-1:0]                index,
    output logic [DATA_WIDTH-1:0]        word
);

    always_comb begin
        word = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (index == IW'(k)) begin
                word = words[k];
            end
        end
    end

endmodule

// File: rtl/conv_result_serializer.sv
// Parallel frame to serial word stream with one frame of shadow buffering,
// so back-to-back frames stream without a bubble.
module conv_result_serializer
    import conv_result_serializer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned N          = DefaultN,
    parameter int unsigned IW         = DefaultIw
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [0:N*DATA_WIDTH-1]     in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [IW-1:0]               out_index,
    output logic                        busy
);

    localparam logic [IW-1:0] LastIndex = IW'(N - 1);

    state_e                        state_q, state_d;
    logic [IW-1:0]                 index_q, index_d;
    logic                          shadow_full_q, shadow_full_d;
    logic [N-1:0][DATA_WIDTH-1:0]  active_q, shadow_q, in_words;
    logic [DATA_WIDTH-1:0]         mux_word;
    logic                          frame_hs, word_hs, last_hs;
    logic                          load_active_in, load_active_shadow, load_shadow;

    always_comb begin
        in_words = '0;
        for (int unsigned k = 0; k < N; k++) begin
            in_words[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign in_ready = !shadow_full_q;
    assign frame_hs = in_valid && in_ready;
    assign word_hs  = out_valid && out_ready;
    assign last_hs  = word_hs && (index_q == LastIndex);

    always_comb begin
        state_d            = state_q;
        index_d            = index_q;
        shadow_full_d      = shadow_full_q;
        load_active_in     = 1'b0;
        load_active_shadow = 1'b0;
        load_shadow        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_hs) begin
                    load_active_in = 1'b1;
                    index_d        = '0;
                    state_d        = StStream;
                end
            end
            StStream: begin
                if (last_hs) begin
                    index_d = '0;
                    // Shadow full implies in_ready low, so no frame can arrive here too.
                    if (shadow_full_q) begin
                        load_active_shadow = 1'b1;
                        shadow_full_d      = 1'b0;
                    end else if (frame_hs) begin
                        load_active_in = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    if (word_hs) begin
                        index_d = index_q + 1'b1;
                    end
                    if (frame_hs) begin
                        load_shadow   = 1'b1;
                        shadow_full_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            index_q       <= '0;
            shadow_full_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            shadow_full_q <= shadow_full_d;
        end
    end

    // Word storage carries no reset; validity is tracked by the control state alone.
    always_ff @(posedge clk) begin
        if (load_active_in) begin
            active_q <= in_words;
        end else if (load_active_shadow) begin
            active_q <= shadow_q;
        end
        if (load_shadow) begin
            shadow_q <= in_words;
        end
    end

    conv_result_serializer_frame_word_mux #(
        .DATA_WIDTH(DATA_WIDTH),
        .N         (N),
        .IW        (IW)
    ) u_frame_word_mux (
        .words(active_q),
        .index(index_q),
        .word (mux_word)
    );

    assign out_valid = (state_q == StStream);
    assign out_data  = out_valid ? mux_word : '0;
    assign out_index = out_valid ? index_q : '0;
    assign out_last  = out_valid && (index_q == LastIndex);
    assign busy      = out_valid || shadow_full_q;

endmodule

// File: tb/tb_conv_result_serializer.sv
// Directed bench for conv_result_serializer: streaming, back-to-back frames,
// random backpressure, same-cycle reload and mid-frame reset.
module tb_conv_result_serializer;

    localparam int unsigned DW = 16;
    localparam int unsigned N  = 128;
    localparam int unsigned IW = 7;

    typedef logic [0:N*DW-1] frame_t;

    localparam logic [26:0] IdleObs = {1'b0, 1'b1, 25'b0};

    logic             clk;
    logic             reset;
    frame_t           in_data;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [IW-1:0]    out_index;
    logic             busy;
    logic [26:0]      obs;

    int vectors     = 0;
    int miscompares = 0;

    conv_result_serializer #(
        .DATA_WIDTH(DW),
        .N         (N),
        .IW        (IW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .out_index(out_index),
        .busy     (busy)
    );

    assign obs = {busy, in_ready, out_valid, out_last, out_index, out_data};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic frame_t frame(logic [15:0] base);
        frame_t f;
        f = '0;
        for (int k = 0; k < N; k++) begin
            f[k*DW +: DW] = base + 16'(k);
        end
        return f;
    endfunction

    // Expected observation while streaming word k of a frame starting at base.
    function automatic logic [26:0] sw(int k, logic [15:0] base, bit rdy);
        return {1'b1, rdy, 1'b1, (k == N - 1), 7'(k), base + 16'(k)};
    endfunction

    task automatic check(string tag, logic [26:0] observed, logic [26:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed=%07h expected=%07h", tag, observed, expected);
        end
    endtask

    // Entered at the negedge where word 0 is visible; out_ready held high.
    task automatic expect_frame(string tag, logic [15:0] base);
        for (int k = 0; k < N; k++) begin
            if (k != 0) @(negedge clk);
            check(tag, obs, sw(k, base, 1'b1));
        end
    endtask

    initial begin
        int idx;
        int cyc;
        bit r;

        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        reset     = 1'b1;
        #2 reset  = 1'b0;
        #20;
        check("reset", obs, IdleObs);
        @(negedge clk);
        reset = 1'b1;
        check("post_reset_idle", obs, IdleObs);

        // Single frame, out_ready constant high.
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = frame(16'h1000);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        expect_frame("single", 16'h1000);
        @(negedge clk);
        check("single_idle", obs, IdleObs);

        // Two back-to-back frames plus a third held off; in_data garbage while not ready.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = frame(16'h1000);
        for (int k = 0; k < 3 * N; k++) begin
            @(negedge clk);
            check("b2b", obs, sw(k % N, 16'h1000 * 16'(k / N + 1),
                                 (k == 0) || (k == N) || (k >= 2 * N)));
            if (k == 0) in_data = frame(16'h2000);
            else if (k == 1 || k == N - 1) in_data = frame(16'h3000);
            else if (k < N - 1) in_data = frame(16'h5000 + 16'(k));
            else if (k == N + 1) in_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b_idle", obs, IdleObs);

        // Random backpressure; each stalled word must stay put.
        in_valid = 1'b1;
        in_data  = frame(16'h1000);
        @(negedge clk);
        in_valid = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < N && cyc < 2000) begin
            check("rand", obs, sw(idx, 16'h1000, 1'b1));
            r = 1'($urandom_range(0, 1));
            out_ready = r;
            if (r) idx++;
            cyc++;
            @(negedge clk);
        end
        check("rand_done", 27'(idx), 27'(N));
        check("rand_idle", obs, IdleObs);
        out_ready = 1'b1;

        // New frame offered on the exact last-word handshake cycle.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = frame(16'h1000);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k != 0) @(negedge clk);
            check("sim_first", obs, sw(k, 16'h1000, 1'b1));
        end
        in_valid = 1'b1;
        in_data  = frame(16'h2000);
        @(negedge clk);
        in_valid = 1'b0;
        expect_frame("sim_second", 16'h2000);
        @(negedge clk);
        check("sim_idle", obs, IdleObs);

        // Reset at index 37 with the shadow full.
        in_valid = 1'b1;
        in_data  = frame(16'h1000);
        @(negedge clk);
        in_data = frame(16'h2000);
        for (int k = 0; k <= 37; k++) begin
            if (k != 0) @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            check("pre_rst", obs, sw(k, 16'h1000, k == 0));
        end
        reset = 1'b0;
        #1;
        check("rst_immediate", obs, IdleObs);
        @(negedge clk);
        check("rst_held", obs, IdleObs);
        reset = 1'b1;
        @(negedge clk);
        check("rst_released", obs, IdleObs);
        in_valid = 1'b1;
        in_data  = frame(16'h4000);
        @(negedge clk);
        in_valid = 1'b0;
        expect_frame("post_rst", 16'h4000);
        @(negedge clk);
        check("post_rst_idle", obs, IdleObs);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_result_serializer.md
CONV_RESULT_SERIALIZER -- requirements
Module: conv_result_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, bit width of one result word.
REQ-002 Parameter N, default 128, number of words per frame (conv output positions).
REQ-003 Parameter IW, default 7, index width; SHALL equal clog2(N).
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  N*DATA_WIDTH  parallel frame, MSB-first bus [0:N*DATA_WIDTH-1]; word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 in_valid  input  1  frame on in_data is valid.
REQ-008 in_ready  output  1  block can accept a frame this cycle.
REQ-009 out_data  output  DATA_WIDTH  current serial word.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_last  output  1  high with word N-1 of a frame.
REQ-013 out_index  output  IW  position (0..N-1) of out_data within its frame.
REQ-014 busy  output  1  high when in STREAM or the shadow buffer is full.

Function
REQ-015 Frame handshake occurs on a rising edge where in_valid && in_ready; word handshake where out_valid && out_ready.
REQ-016 Storage: active buffer (N words) and shadow buffer (N words) with flag shadow_full.
REQ-017 in_ready SHALL equal !shadow_full; it SHALL NOT depend combinationally on in_valid.
REQ-018 FSM states IDLE and STREAM; out_valid SHALL be 1 exactly in STREAM.
REQ-019 IDLE + frame handshake -> capture in_data into active, index <= 0, go STREAM; out_valid rises the next cycle (1-cycle latency), word 0 presented.
REQ-020 STREAM + frame handshake, no last-word handshake -> capture into shadow, shadow_full <= 1.
REQ-021 STREAM + word handshake with index < N-1 -> index <= index+1.
REQ-022 STREAM + last-word handshake (index == N-1), shadow_full -> active <= shadow, shadow_full <= 0, index <= 0, stay STREAM (no bubble).
REQ-023 STREAM + last-word handshake, shadow empty, simultaneous frame handshake -> in_data loaded directly into active, index <= 0, stay STREAM.
REQ-024 STREAM + last-word handshake, shadow empty, no frame handshake -> go IDLE, index <= 0.
REQ-025 out_data SHALL equal active word [index]; out_data, out_index, out_last SHALL hold stable while out_valid && !out_ready.
REQ-026 out_last SHALL equal out_valid && (index == N-1).
REQ-027 in_data SHALL be sampled only on a frame handshake; changes at other times have no effect.
REQ-028 Words are passed bit-exact; no arithmetic, truncation or sign change.
REQ-029 Frames SHALL be emitted in acceptance order; none dropped or duplicated.

Reset
REQ-030 reset low SHALL immediately force IDLE, index 0, shadow_full 0, out_valid 0, out_last 0, out_index 0, out_data 0, busy 0, in_ready 1.
REQ-031 Reset mid-frame SHALL discard active and shadow contents; the first post-reset frame starts at index 0.
REQ-032 Buffer data registers need not be reset; only control state and outputs.

Structure
REQ-033 Shared package holds DATA_WIDTH default, N default, IW, and the state encoding (IDLE=0, STREAM=1).
REQ-034 One sub-module natural: frame_word_mux (N-to-1 DATA_WIDTH selector by index), purely combinational.
REQ-035 No other sub-modules; single clock domain.

Verification
REQ-036 Frame k-th word = 16'h1000+k, out_ready=1 constant -> out_valid rises 1 cycle after handshake, 128 consecutive words 16'h1000..16'h107F, out_last only on 16'h107F, then IDLE.
REQ-037 Two frames (16'h1000+k, 16'h2000+k) presented back-to-back, out_ready=1 -> 256 contiguous valid cycles, no bubble between 16'h107F and 16'h2000, third frame held off (in_ready=0) until shadow drains.
REQ-038 out_ready random 50% duty -> every stalled word (value, index, last) stable until accepted; sequence identical to REQ-036.
REQ-039 Frame offered on exact cycle of last-word handshake with shadow empty -> accepted, next cycle out_data=word 0 of new frame, out_index=0.
REQ-040 reset pulsed low at index 37 with shadow full -> outputs zero immediately, in_ready=1; next frame streams from index 0, old data never appears.
REQ-041 in_data toggled while in_ready=0 -> streamed words unaffected.
